// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 16x-oversampled UART receiver feeding an FWFT byte FIFO.
//            Define UART_RX_PARITY_EN for 8E1 frames; default build is 8N1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
   parameter int CLK_DIV = 434,
   parameter int FIFO_AW = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   input  logic       ovf_clr,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int PTR_W = FIFO_AW + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t             state_q;
   logic [2:0]         rx_sync_q;
   logic [DIV_W-1:0]   div_q;
   logic [3:0]         samp_q;
   logic [2:0]         idx_q;
   logic [7:0]         shift_q;
   logic               push_q;
   logic               frame_err_q;
`ifdef UART_RX_PARITY_EN
   logic               par_bad_q;
   logic               parity_err_q;
`endif

   logic               w_rx;
   logic               w_fall;
   logic               w_tick;
   logic               w_mid;

   // rx_sync_q[1] is the synchronised line; [2] is its one-cycle history for edge detect
   assign w_rx   = rx_sync_q[1];
   assign w_fall = rx_sync_q[2] & ~rx_sync_q[1];
   assign w_tick = (state_q != S_IDLE) && (div_q == DIV_LAST);
   assign w_mid  = w_tick && (samp_q == 4'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rx_sync_q   <= 3'b111;
         div_q       <= '0;
         samp_q      <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_sync_q   <= {rx_sync_q[1:0], rx};
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         // Counters sit at zero in IDLE so a start edge always begins a fresh bit period
         if (state_q == S_IDLE) begin
            div_q  <= '0;
            samp_q <= '0;
         end else if (w_tick) begin
            div_q  <= '0;
            samp_q <= samp_q + 4'd1;
         end else begin
            div_q  <= div_q + DIV_W'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (w_fall) state_q <= S_START;
            end
            S_START: begin
               if (w_mid) begin
                  idx_q   <= '0;
                  state_q <= w_rx ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (w_mid) begin
                  shift_q[idx_q] <= w_rx;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_mid) begin
                  par_bad_q <= w_rx ^ (^shift_q);
                  state_q   <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (w_mid) begin
`ifdef UART_RX_PARITY_EN
                  parity_err_q <= par_bad_q;
                  push_q       <= w_rx & ~par_bad_q;
`else
                  push_q       <= w_rx;
`endif
                  frame_err_q  <= ~w_rx;
                  state_q      <= w_rx ? S_IDLE : S_BREAK;
               end
            end
            S_BREAK: begin
               if (w_rx) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic             ovf_q, ovf_d;
   logic             w_pop;
   logic             w_push;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                  (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);

   // A pop in the same cycle frees the slot, so a push at full still lands
   always_comb begin
      w_pop  = rd_en & ~empty;
      w_push = push_q & (~full | w_pop);
      wr_d   = wr_q + PTR_W'(w_push);
      rd_d   = rd_q + PTR_W'(w_pop);
      ovf_d  = ovf_q;
      if (push_q && full && !w_pop) ovf_d = 1'b1;
      else if (ovf_clr)             ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_q[FIFO_AW-1:0]] <= shift_q;
   end

   assign rd_data  = empty ? 8'h00 : mem_q[rd_q[FIFO_AW-1:0]];
   assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Scoreboard bench for uart_rx_fifo at CLK_DIV=1 (one bit = 16 clk).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx      = 1'b1;
   logic       rd_en   = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic       overflow;
   logic       frame_err;
   logic       parity_err;

   int         checks = 0;
   int         errors = 0;
   int         fe_cnt = 0;
   int         pe_cnt = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_DIV(1), .FIFO_AW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   // Counts high cycles, so a single pulse adds exactly one
   always @(negedge clk) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int stop_len, input int gap);
      rx = 1'b0;
      cycles(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cycles(16);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      cycles(16);
`else
      if (par) $display("note: parity bit ignored in 8N1 build");
`endif
      rx = stop;
      cycles(stop_len);
      rx = 1'b1;
      cycles(gap);
   endtask

   // Pops n bytes off the DUT and compares against the scoreboard queue
   task automatic sb_drain(input int n, input string name);
      logic [7:0] exp;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (empty !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d]: empty=%b required 0", name, i, empty);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s[%0d]: got byte %h, scoreboard empty", name, i, rd_data);
         end else begin
            exp = exp_q.pop_front();
            if (rd_data !== exp) begin
               errors++;
               $display("FAIL %s[%0d]: rd_data=%h required %h", name, i, rd_data, exp);
            end
         end
         rd_en = 1'b1;
         cycles(1);
         rd_en = 1'b0;
      end
   endtask

   task automatic test_reset();
      cycles(3);
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b required 1", empty); end
      checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b required 0", full); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b required 0", overflow); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b required 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b required 0", parity_err); end
      checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL reset_rd_data: got %h required 00", rd_data); end
      rst_n = 1'b1;
      cycles(5);
   endtask

   task automatic test_single();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, 16, 16);
      sb_drain(1, "single");
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop: got %b required 1", empty); end
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      rx = 1'b0;
      cycles(4);
      rx = 1'b1;
      cycles(40);
      checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL glitch_empty: got %b required 1", empty); end
      checks++; if (fe_cnt != fe0)   begin errors++; $display("FAIL glitch_ferr: pulses %0d required 0", fe_cnt - fe0); end
      exp_q.push_back(8'h96);
      send_frame(8'h96, 1'b0, 1'b1, 16, 16);
      sb_drain(1, "after_glitch");
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 40, 16);
      checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL frame_err_pulse: cycles %0d required 1", fe_cnt - fe0); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL frame_err_empty: got %b required 1", empty); end
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1, 16, 16);
      sb_drain(1, "after_break");
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [3];
      b[0] = 8'h01; b[1] = 8'hFE; b[2] = 8'h6D;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(b[i]);
         send_frame(b[i], 1'b0, 1'b1, 16, 0);
      end
      cycles(8);
      sb_drain(3, "b2b");
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b required 1", empty); end
   endtask

   task automatic fill_nine(input string name);
      for (int v = 0; v < 9; v++) begin
         if (v < 8) exp_q.push_back(8'(v));
         send_frame(8'(v), 1'b0, 1'b1, 16, 16);
         if (v == 7) begin
            checks++; if (full !== 1'b1)     begin errors++; $display("FAIL %s_full_at_8: got %b required 1", name, full); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s_ovf_at_8: got %b required 0", name, overflow); end
         end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL %s_ovf_set: got %b required 1", name, overflow); end
      checks++; if (full !== 1'b1)     begin errors++; $display("FAIL %s_full_kept: got %b required 1", name, full); end
   endtask

   task automatic test_overflow();
      fill_nine("ovf");
      sb_drain(8, "ovf_read");
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL ovf_empty: got %b required 1", empty); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'h77;
      rx = 1'b0;
      cycles(16);
      for (int i = 0; i < 3; i++) begin
         rx = d[i];
         cycles(16);
      end
      rx = d[3];
      cycles(8);
      rst_n = 1'b0;
      rx    = 1'b1;
      cycles(2);
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL midrst_empty: got %b required 1", empty); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b required 0", overflow); end
      cycles(3);
      rst_n = 1'b1;
      cycles(40);
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL midrst_discard: got %b required 1", empty); end
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b0, 1'b1, 16, 16);
      sb_drain(1, "after_midrst");
   endtask

   task automatic test_ovf_clr();
      fill_nine("clr");
      ovf_clr = 1'b1;
      cycles(1);
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", overflow); end
      sb_drain(8, "clr_read");
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL clr_empty: got %b required 1", empty); end
   endtask

   task automatic test_parity();
`ifdef UART_RX_PARITY_EN
      int pe0;
      pe0 = pe_cnt;
      send_frame(8'h81, 1'b1, 1'b1, 16, 16);
      checks++; if (pe_cnt != pe0 + 1) begin errors++; $display("FAIL parity_err_pulse: cycles %0d required 1", pe_cnt - pe0); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL parity_drop: empty=%b required 1", empty); end
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b0, 1'b1, 16, 16);
      checks++; if (pe_cnt != pe0 + 1) begin errors++; $display("FAIL parity_good: extra pulses %0d required 0", pe_cnt - pe0 - 1); end
      sb_drain(1, "parity_ok");
`else
      checks++; if (pe_cnt != 0) begin errors++; $display("FAIL parity_tied: pulses %0d required 0", pe_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_overflow();
      test_reset_midframe();
      test_ovf_clr();
      test_parity();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d bytes required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
